// File: rtl/trex_game_core.sv
// T-rex runner core: jump physics with gravity, N obstacle slots with distance-based spawning,
// bounding-box collision, score and speed ramp. Game state advances only on frame_tick while running.
module trex_game_core #(
    parameter int SCREEN_W   = 640,
    parameter int GROUND_Y   = 250,
    parameter int REX_X      = 50,
    parameter int REX_W      = 20,
    parameter int OBS_W      = 12,
    parameter int OBS_H      = 20,
    parameter int N_OBS      = 2,
    parameter int JUMP_V     = 15,
    parameter int GRAVITY    = 1,
    parameter int SPEED_INIT = 4,
    parameter int SPEED_MAX  = 12,
    parameter int SPEED_STEP = 100,
    parameter int OBS_GAP    = 320
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                btn_start,
    input  logic                btn_jump,
    output logic [9:0]          rex_y,
    output logic [10*N_OBS-1:0] obs_x,
    output logic [N_OBS-1:0]    obs_active,
    output logic [15:0]         score,
    output logic [4:0]          speed,
    output logic                game_over
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    localparam logic [9:0]  SPAWN_X   = 10'(SCREEN_W);
    localparam logic [9:0]  GROUND    = 10'(GROUND_Y);
    localparam logic [9:0]  LAUNCH_Y  = 10'(GROUND_Y - JUMP_V);
    localparam logic [9:0]  HIT_Y     = 10'(GROUND_Y - OBS_H);
    localparam logic [10:0] REX_L     = 11'(REX_X);
    localparam logic [10:0] REX_R     = 11'(REX_X + REX_W);
    localparam logic [10:0] OBS_W11   = 11'(OBS_W);
    localparam logic [7:0]  LAUNCH_V  = 8'(GRAVITY - JUMP_V);
    localparam logic [7:0]  GRAV_V    = 8'(GRAVITY);
    localparam logic [4:0]  SPD_INIT  = 5'(SPEED_INIT);
    localparam logic [4:0]  SPD_MAX   = 5'(SPEED_MAX);
    localparam logic [15:0] STEP_LAST = 16'(SPEED_STEP - 1);
    localparam logic [15:0] GAP       = 16'(OBS_GAP);

    logic [1:0]        state;
    logic signed [7:0] vel;
    logic              airborne;
    logic              jump_q;
    logic              jump_pending;
    logic              jump_rise;
    logic [15:0]       acc;
    logic [15:0]       step_cnt;
    logic [9:0]        obs_pos [N_OBS];

    logic [9:0]        pos_nxt [N_OBS];
    logic [N_OBS-1:0]  act_nxt;
    logic [15:0]       acc_sum;
    logic [15:0]       acc_nxt;
    logic              spawn_req;
    logic              spawn_free;
    logic              collide;
    logic signed [11:0] y_sum;
    logic              land;

    assign jump_rise = btn_jump & ~jump_q;
    assign game_over = (state == S_OVER);
    assign y_sum     = $signed({2'b00, rex_y}) + 12'(vel);
    assign land      = (y_sum >= $signed({2'b00, GROUND}));

    always_comb begin
        obs_x = '0;
        for (int i = 0; i < N_OBS; i++) obs_x[10*i +: 10] = obs_pos[i];
    end

    // Hit test uses registered pre-update positions of rex and every active slot.
    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < N_OBS; i++) begin
            if (obs_active[i] && ({1'b0, obs_pos[i]} < REX_R) &&
                (({1'b0, obs_pos[i]} + OBS_W11) > REX_L) && (rex_y > HIT_Y))
                collide = 1'b1;
        end
    end

    // Spawning only considers slots that were already free before this tick's movement.
    always_comb begin
        pos_nxt    = obs_pos;
        act_nxt    = obs_active;
        spawn_free = 1'b1;
        acc_sum    = acc + {11'd0, speed};
        spawn_req  = (acc_sum >= GAP);
        acc_nxt    = spawn_req ? (acc_sum - GAP) : acc_sum;
        for (int i = 0; i < N_OBS; i++) begin
            if (obs_active[i]) begin
                if ({1'b0, obs_pos[i]} < {6'd0, speed})
                    act_nxt[i] = 1'b0;
                else
                    pos_nxt[i] = 10'({1'b0, obs_pos[i]} - {6'd0, speed});
            end else if (spawn_req && spawn_free) begin
                pos_nxt[i] = SPAWN_X;
                act_nxt[i] = 1'b1;
                spawn_free = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            rex_y        <= GROUND;
            vel          <= '0;
            airborne     <= 1'b0;
            jump_q       <= 1'b0;
            jump_pending <= 1'b0;
            obs_active   <= '0;
            score        <= '0;
            speed        <= SPD_INIT;
            acc          <= '0;
            step_cnt     <= '0;
            for (int i = 0; i < N_OBS; i++) obs_pos[i] <= SPAWN_X;
        end else begin
            jump_q <= btn_jump;
            case (state)
                S_IDLE: begin
                    jump_pending <= 1'b0;
                    if (btn_start) state <= S_RUN;
                end
                S_RUN: begin
                    if (frame_tick) begin
                        if (collide) begin
                            state        <= S_OVER;
                            jump_pending <= 1'b0;
                        end else begin
                            jump_pending <= jump_rise;
                            if (!airborne) begin
                                if (jump_pending) begin
                                    rex_y    <= LAUNCH_Y;
                                    vel      <= LAUNCH_V;
                                    airborne <= 1'b1;
                                end
                            end else if (land) begin
                                rex_y    <= GROUND;
                                vel      <= '0;
                                airborne <= 1'b0;
                            end else begin
                                rex_y <= y_sum[9:0];
                                vel   <= vel + GRAV_V;
                            end
                            obs_pos    <= pos_nxt;
                            obs_active <= act_nxt;
                            acc        <= acc_nxt;
                            if (score != 16'hFFFF) score <= score + 16'd1;
                            if (step_cnt == STEP_LAST) begin
                                step_cnt <= '0;
                                if (speed < SPD_MAX) speed <= speed + 5'd1;
                            end else begin
                                step_cnt <= step_cnt + 16'd1;
                            end
                        end
                    end else if (jump_rise) begin
                        jump_pending <= 1'b1;
                    end
                end
                S_OVER: begin
                    jump_pending <= 1'b0;
                    if (btn_start) begin
                        state      <= S_IDLE;
                        rex_y      <= GROUND;
                        vel        <= '0;
                        airborne   <= 1'b0;
                        obs_active <= '0;
                        score      <= '0;
                        speed      <= SPD_INIT;
                        acc        <= '0;
                        step_cnt   <= '0;
                        for (int i = 0; i < N_OBS; i++) obs_pos[i] <= SPAWN_X;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trex_game_core.sv
// Bench for trex_game_core: three differently parameterised instances share stimulus and are
// compared every cycle against a closed-form game model, plus directed tick-count vectors.
module tb_trex_game_core;
  localparam int G = 250, JV = 15, GRAV = 1, RX = 50, RW = 20, OW = 12, OH = 20;
  localparam int SW = 640, SINIT = 4, SMAX = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic btn_start = 1'b0;
  logic btn_jump = 1'b0;

  logic [9:0] y0, y1, y2;
  logic [19:0] x0, x2;
  logic [9:0] x1;
  logic [1:0] a0, a2;
  logic a1;
  logic [15:0] sc0, sc1, sc2;
  logic [4:0] sp0, sp1, sp2;
  logic go0, go1, go2;

  int n_pass = 0;
  int n_total = 0;
  int tcount = 0;
  bit model_on = 1'b0;

  trex_game_core #(.SPEED_STEP(1000)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_start(btn_start), .btn_jump(btn_jump),
    .rex_y(y0), .obs_x(x0), .obs_active(a0), .score(sc0), .speed(sp0), .game_over(go0));
  trex_game_core #(.N_OBS(1), .OBS_GAP(100)) dut_one (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_start(btn_start), .btn_jump(btn_jump),
    .rex_y(y1), .obs_x(x1), .obs_active(a1), .score(sc1), .speed(sp1), .game_over(go1));
  trex_game_core #(.SPEED_STEP(5)) dut_fast (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_start(btn_start), .btn_jump(btn_jump),
    .rex_y(y2), .obs_x(x2), .obs_active(a2), .score(sc2), .speed(sp2), .game_over(go2));

  // clock
  initial forever #5 clk = ~clk;

  function automatic int p_nobs(int k); return (k == 1) ? 1 : 2; endfunction
  function automatic int p_gap(int k); return (k == 1) ? 100 : 320; endfunction
  function automatic int p_step(int k); return (k == 0) ? 1000 : ((k == 1) ? 100 : 5); endfunction

  function automatic int dut_y(int k);
    case (k) 0: return int'(y0); 1: return int'(y1); default: return int'(y2); endcase
  endfunction
  function automatic int dut_x(int k, int i);
    case (k) 0: return int'(x0[10*i +: 10]); 1: return int'(x1); default: return int'(x2[10*i +: 10]); endcase
  endfunction
  function automatic int dut_a(int k, int i);
    case (k) 0: return int'(a0[i]); 1: return int'(a1); default: return int'(a2[i]); endcase
  endfunction
  function automatic int dut_sc(int k);
    case (k) 0: return int'(sc0); 1: return int'(sc1); default: return int'(sc2); endcase
  endfunction
  function automatic int dut_sp(int k);
    case (k) 0: return int'(sp0); 1: return int'(sp1); default: return int'(sp2); endcase
  endfunction
  function automatic int dut_go(int k);
    case (k) 0: return int'(go0); 1: return int'(go1); default: return int'(go2); endcase
  endfunction

  // reference model: 0=idle 1=run 2=over; rex height is closed-form in ticks since launch
  int m_state [3];
  int m_n [3];
  int m_played [3];
  int m_acc [3];
  bit m_prevj [3];
  bit m_pend [3];
  bit m_air [3];
  int m_ox [3][2];
  bit m_oa [3][2];

  function automatic int m_y(int k);
    if (!m_air[k]) return G;
    return G - JV * m_n[k] + GRAV * m_n[k] * (m_n[k] - 1) / 2;
  endfunction
  function automatic int m_speed(int k);
    int s;
    s = SINIT + m_played[k] / p_step(k);
    return (s > SMAX) ? SMAX : s;
  endfunction
  function automatic int m_score(int k);
    return (m_played[k] > 65535) ? 65535 : m_played[k];
  endfunction

  task automatic model_clear(input int k);
    m_state[k] = 0; m_n[k] = 0; m_played[k] = 0; m_acc[k] = 0;
    m_prevj[k] = 0; m_pend[k] = 0; m_air[k] = 0;
    for (int i = 0; i < 2; i++) begin m_ox[k][i] = SW; m_oa[k][i] = 0; end
  endtask

  task automatic model_step(input int k, input bit tick, input bit start, input bit jump);
    bit rise, coll, found;
    bit was [2];
    int s;
    rise = jump && !m_prevj[k];
    m_prevj[k] = jump;
    if (m_state[k] == 0) begin
      m_pend[k] = 0;
      if (start) m_state[k] = 1;
    end else if (m_state[k] == 2) begin
      m_pend[k] = 0;
      if (start) begin model_clear(k); m_prevj[k] = jump; end
    end else if (!tick) begin
      if (rise) m_pend[k] = 1;
    end else begin
      coll = 0;
      for (int i = 0; i < p_nobs(k); i++)
        if (m_oa[k][i] && m_ox[k][i] < RX + RW && m_ox[k][i] + OW > RX && m_y(k) > G - OH) coll = 1;
      if (coll) begin
        m_state[k] = 2;
        m_pend[k] = 0;
      end else begin
        s = m_speed(k);
        if (m_air[k]) begin
          m_n[k]++;
          if (m_y(k) >= G) begin m_air[k] = 0; m_n[k] = 0; end
        end else if (m_pend[k]) begin
          m_air[k] = 1; m_n[k] = 1;
        end
        for (int i = 0; i < p_nobs(k); i++) begin
          was[i] = m_oa[k][i];
          if (was[i]) begin
            if (m_ox[k][i] < s) m_oa[k][i] = 0;
            else m_ox[k][i] -= s;
          end
        end
        m_acc[k] += s;
        if (m_acc[k] >= p_gap(k)) begin
          m_acc[k] -= p_gap(k);
          found = 0;
          for (int i = 0; i < p_nobs(k); i++)
            if (!was[i] && !found) begin m_ox[k][i] = SW; m_oa[k][i] = 1; found = 1; end
        end
        m_played[k]++;
        m_pend[k] = rise;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) model_clear(k);
      else model_step(k, frame_tick, btn_start, btn_jump);
    end
  end

  // scoreboard
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_d%0d_rex_y", k), dut_y(k), m_y(k));
      chk($sformatf("model_d%0d_score", k), dut_sc(k), m_score(k));
      chk($sformatf("model_d%0d_speed", k), dut_sp(k), m_speed(k));
      chk($sformatf("model_d%0d_game_over", k), dut_go(k), int'(m_state[k] == 2));
      for (int i = 0; i < p_nobs(k); i++) begin
        chk($sformatf("model_d%0d_active%0d", k, i), dut_a(k, i), int'(m_oa[k][i]));
        if (m_oa[k][i]) chk($sformatf("model_d%0d_x%0d", k, i), dut_x(k, i), m_ox[k][i]);
      end
    end
  endtask

  always @(negedge clk) if (model_on) compare_all();

  // driver tasks
  task automatic tick_once();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    tcount++;
  endtask
  task automatic run_to(input int target);
    while (tcount < target) tick_once();
  endtask
  task automatic pulse_jump();
    @(negedge clk); btn_jump = 1'b1;
    @(negedge clk); btn_jump = 1'b0;
  endtask
  task automatic pulse_start(input bit with_tick);
    @(negedge clk); btn_start = 1'b1; frame_tick = with_tick;
    @(negedge clk); btn_start = 1'b0; frame_tick = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); #2 reset = 1'b0;
  endtask
  task automatic start_fresh();
    do_reset();
    pulse_start(1'b0);
    tcount = 0;
  endtask

  typedef struct {
    bit press;
    int n_ticks;
    int exp_y;
    int exp_score;
  } vec_t;

  vec_t jump_vec [5];

  initial begin
    jump_vec[0] = '{1'b1, 1, 235, 1};
    jump_vec[1] = '{1'b0, 14, 130, 15};
    jump_vec[2] = '{1'b1, 15, 235, 30};
    jump_vec[3] = '{1'b0, 1, 250, 31};
    jump_vec[4] = '{1'b0, 5, 250, 36};

    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    model_on = 1'b1;

    // reset values, and ticks in IDLE do nothing
    @(negedge clk);
    chk("reset_rex_y", dut_y(0), 250);
    chk("reset_x0", dut_x(0, 0), 640);
    chk("reset_x1", dut_x(0, 1), 640);
    chk("reset_active", int'(a0), 0);
    chk("reset_score", dut_sc(0), 0);
    chk("reset_speed", dut_sp(0), 4);
    chk("reset_game_over", dut_go(0), 0);
    tick_once(); tick_once();
    chk("idle_tick_score", dut_sc(0), 0);

    // start together with a tick: only the transition happens
    pulse_start(1'b1);
    chk("start_tick_score", dut_sc(0), 0);
    tcount = 0;
    for (int v = 0; v < 5; v++) begin
      if (jump_vec[v].press) pulse_jump();
      repeat (jump_vec[v].n_ticks) tick_once();
      chk($sformatf("jump_vec%0d_rex_y", v), dut_y(0), jump_vec[v].exp_y);
      chk($sformatf("jump_vec%0d_score", v), dut_sc(0), jump_vec[v].exp_score);
    end

    // held jump button gives a single jump
    start_fresh();
    @(negedge clk); btn_jump = 1'b1;
    run_to(15); chk("hold_apex", dut_y(0), 130);
    run_to(31); chk("hold_land", dut_y(0), 250);
    run_to(40); chk("hold_no_retrigger", dut_y(0), 250);
    @(negedge clk); btn_jump = 1'b0;

    // no jumping: spawn, drop on a busy slot, speed ramp, collision and freeze
    start_fresh();
    run_to(25); chk("one_spawn_active", dut_a(1, 0), 1); chk("one_spawn_x", dut_x(1, 0), 640);
    run_to(39); chk("fast_speed_39", dut_sp(2), 11);
    run_to(40); chk("fast_speed_40", dut_sp(2), 12);
    run_to(50); chk("one_drop_x", dut_x(1, 0), 540); chk("one_drop_active", dut_a(1, 0), 1);
    run_to(60); chk("fast_speed_60", dut_sp(2), 12);
    run_to(75); chk("one_x_75", dut_x(1, 0), 440);
    run_to(79); chk("pre_spawn_active", int'(a0), 0);
    run_to(80); chk("spawn_active", int'(a0), 1); chk("spawn_x", dut_x(0, 0), 640);
    run_to(223); chk("approach_x", dut_x(0, 0), 68); chk("approach_go", dut_go(0), 0);
    run_to(224); chk("hit_go", dut_go(0), 1); chk("hit_score", dut_sc(0), 223);
    run_to(230); chk("frozen_score", dut_sc(0), 223); chk("frozen_x", dut_x(0, 0), 68);

    // btn_start in GAME_OVER restores reset values and lands in IDLE
    pulse_start(1'b0);
    chk("restart_go", dut_go(0), 0);
    chk("restart_score", dut_sc(0), 0);
    chk("restart_active", int'(a0), 0);
    chk("restart_x0", dut_x(0, 0), 640);
    chk("restart_speed", dut_sp(0), 4);
    tick_once();
    chk("restart_idle_score", dut_sc(0), 0);
    pulse_start(1'b0);
    tick_once();
    chk("restart_run_score", dut_sc(0), 1);

    // timed jump clears the obstacle, which then expires at the left edge
    start_fresh();
    run_to(221); chk("dodge_x_before", dut_x(0, 0), 76);
    pulse_jump();
    run_to(240); chk("dodge_active_240", int'(a0), 3); chk("dodge_x_240", dut_x(0, 0), 0);
    chk("dodge_go_240", dut_go(0), 0);
    run_to(241); chk("expire_active", int'(a0), 2);
    run_to(260); chk("dodge_score", dut_sc(0), 260); chk("dodge_go", dut_go(0), 0);
    chk("dodge_landed", dut_y(0), 250);

    // reset in the middle of a jump
    start_fresh();
    pulse_jump();
    run_to(5); chk("midjump_y", dut_y(0), 185);
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk);
    chk("midreset_y", dut_y(0), 250);
    chk("midreset_active", int'(a0), 0);
    chk("midreset_score", dut_sc(0), 0);
    chk("midreset_go", dut_go(0), 0);
    #2 reset = 1'b0;
    tick_once(); tick_once();
    chk("midreset_idle", dut_sc(0), 0);

    // random play against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) btn_jump = ~btn_jump;
      btn_start = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    frame_tick = 1'b0; btn_jump = 1'b0; btn_start = 1'b0;
    @(negedge clk);
    model_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
